instruction_cache_controller: RTL and testbench

- Direct-mapped, read-only instruction cache between the fetch stage and main_memory_controller.
- Serves 32-bit instruction fetches from 128-bit lines.
- On a miss it acts as initiator on the block-read interface: it drives address and request-valid, waits for ready, then captures the returned block.
- Line fill and the fetch response complete in the cycle after memory ready.

---
 rtl/instruction_cache_controller_pkg.sv | 33 +++
 rtl/instruction_cache_controller_line_store.sv | 49 ++++
 rtl/instruction_cache_controller.sv | 121 ++++++++++++
 tb/tb_instruction_cache_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_controller_pkg.sv
// Shared widths, FSM state type and word-select helper for the instruction cache.
`ifndef BUYRUK_ADRES_BIT
`define BUYRUK_ADRES_BIT 32
`endif
`ifndef BUYRUK_BLOK_BIT
`define BUYRUK_BLOK_BIT 128
`endif
`ifndef BUYRUK_KELIME_BIT
`define BUYRUK_KELIME_BIT 32
`endif
`ifndef BLOK_OFSET_BIT
`define BLOK_OFSET_BIT 4
`endif

package instruction_cache_controller_pkg;

   localparam int KELIME_SECIM_BIT = `BLOK_OFSET_BIT - 2;

   typedef enum logic [1:0] {
      BOSTA        = 2'd0,
      ARA          = 2'd1,
      BELLEK_BEKLE = 2'd2
   } durum_t;

   // Word 0 sits in the least significant 32 bits of the block.
   function automatic logic [`BUYRUK_KELIME_BIT-1:0] kelime_sec(
      input logic [`BUYRUK_BLOK_BIT-1:0] blok,
      input logic [KELIME_SECIM_BIT-1:0] kelime
   );
      return blok[kelime*`BUYRUK_KELIME_BIT +: `BUYRUK_KELIME_BIT];
   endfunction

endpackage

// File: rtl/instruction_cache_controller_line_store.sv
// Direct-mapped line storage: data, tag and valid arrays with async read and one sync write port.
module instruction_cache_line_store
   import instruction_cache_controller_pkg::*;
#(
   parameter int SATIR_SAYISI = 8,
   parameter int INDIS_BIT    = $clog2(SATIR_SAYISI),
   parameter int ETIKET_BIT   = `BUYRUK_ADRES_BIT - `BLOK_OFSET_BIT - INDIS_BIT
)(
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [INDIS_BIT-1:0]        okuma_indis,
   output logic [`BUYRUK_BLOK_BIT-1:0] okuma_veri,
   output logic [ETIKET_BIT-1:0]       okuma_etiket,
   output logic                        okuma_gecerli,
   input  logic                        yazma_en,
   input  logic [INDIS_BIT-1:0]        yazma_indis,
   input  logic [`BUYRUK_BLOK_BIT-1:0] yazma_veri,
   input  logic [ETIKET_BIT-1:0]       yazma_etiket,
   input  logic                        temizle
);

   logic [`BUYRUK_BLOK_BIT-1:0] veri_dizi   [SATIR_SAYISI];
   logic [ETIKET_BIT-1:0]       etiket_dizi [SATIR_SAYISI];
   logic [SATIR_SAYISI-1:0]     gecerli_dizi;

   assign okuma_veri    = veri_dizi[okuma_indis];
   assign okuma_etiket  = etiket_dizi[okuma_indis];
   assign okuma_gecerli = gecerli_dizi[okuma_indis];

   always_ff @(posedge clk_i) begin
      if (yazma_en) begin
         veri_dizi[yazma_indis]   <= yazma_veri;
         etiket_dizi[yazma_indis] <= yazma_etiket;
      end
   end

   // A fill landing on the same edge as a flush keeps its own line valid.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         gecerli_dizi <= '0;
      end else begin
         if (temizle)
            gecerli_dizi <= '0;
         if (yazma_en)
            gecerli_dizi[yazma_indis] <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_cache_controller.sv
// Direct-mapped read-only instruction cache; fills 128-bit lines over a block-read interface.
module instruction_cache_controller
   import instruction_cache_controller_pkg::*;
#(
   parameter int SATIR_SAYISI = 8
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [`BUYRUK_ADRES_BIT-1:0] getir_istek_adres_i,
   input  logic                         getir_istek_gecerli_i,
   output logic                         getir_hazir_o,
   output logic [`BUYRUK_KELIME_BIT-1:0] getir_buyruk_o,
   output logic                         getir_buyruk_gecerli_o,
   input  logic                         onbellek_temizle_i,
   output logic [`BUYRUK_ADRES_BIT-1:0] denetleyici_okuma_istek_adres_o,
   output logic                         denetleyici_okuma_istek_gecerli_o,
   input  logic [`BUYRUK_BLOK_BIT-1:0]  denetleyici_okuma_veri_blok_i,
   input  logic                         denetleyici_okuma_istek_hazir_i
);

   localparam int INDIS_BIT  = $clog2(SATIR_SAYISI);
   localparam int ETIKET_BIT = `BUYRUK_ADRES_BIT - `BLOK_OFSET_BIT - INDIS_BIT;

   durum_t durum, durum_sonraki;

   logic [`BUYRUK_ADRES_BIT-1:0] adres_q;
   logic [ETIKET_BIT-1:0]        etiket;
   logic [INDIS_BIT-1:0]         indis;
   logic [KELIME_SECIM_BIT-1:0]  kelime;
   logic                         unused_bayt_bit;

   logic [`BUYRUK_BLOK_BIT-1:0]  satir_veri;
   logic [ETIKET_BIT-1:0]        satir_etiket;
   logic                         satir_gecerli;
   logic                         isabet;
   logic                         dolum;

   assign etiket          = adres_q[`BUYRUK_ADRES_BIT-1 -: ETIKET_BIT];
   assign indis           = adres_q[`BLOK_OFSET_BIT +: INDIS_BIT];
   assign kelime          = adres_q[`BLOK_OFSET_BIT-1:2];
   assign unused_bayt_bit = ^adres_q[1:0];

   instruction_cache_line_store #(
      .SATIR_SAYISI (SATIR_SAYISI),
      .INDIS_BIT    (INDIS_BIT),
      .ETIKET_BIT   (ETIKET_BIT)
   ) u_line_store (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .okuma_indis   (indis),
      .okuma_veri    (satir_veri),
      .okuma_etiket  (satir_etiket),
      .okuma_gecerli (satir_gecerli),
      .yazma_en      (dolum),
      .yazma_indis   (indis),
      .yazma_veri    (denetleyici_okuma_veri_blok_i),
      .yazma_etiket  (etiket),
      .temizle       (onbellek_temizle_i)
   );

   // A flush sampled during lookup must not let a now-stale line hit.
   assign isabet = satir_gecerli && (satir_etiket == etiket) && !onbellek_temizle_i;
   assign dolum  = (durum == BELLEK_BEKLE) && denetleyici_okuma_istek_hazir_i;

   assign getir_hazir_o = (durum == BOSTA) && rst_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i)
         durum <= BOSTA;
      else
         durum <= durum_sonraki;
   end

   always_comb begin
      durum_sonraki = durum;
      case (durum)
         BOSTA:        if (getir_istek_gecerli_i) durum_sonraki = ARA;
         ARA:          durum_sonraki = isabet ? BOSTA : BELLEK_BEKLE;
         BELLEK_BEKLE: if (denetleyici_okuma_istek_hazir_i) durum_sonraki = BOSTA;
         default:      durum_sonraki = BOSTA;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (durum == BOSTA && getir_istek_gecerli_i)
         adres_q <= getir_istek_adres_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         getir_buyruk_o                    <= '0;
         getir_buyruk_gecerli_o            <= 1'b0;
         denetleyici_okuma_istek_gecerli_o <= 1'b0;
         denetleyici_okuma_istek_adres_o   <= '0;
      end else begin
         getir_buyruk_gecerli_o <= 1'b0;
         case (durum)
            ARA: begin
               if (isabet) begin
                  getir_buyruk_o         <= kelime_sec(satir_veri, kelime);
                  getir_buyruk_gecerli_o <= 1'b1;
               end else begin
                  denetleyici_okuma_istek_gecerli_o <= 1'b1;
                  denetleyici_okuma_istek_adres_o   <=
                     {adres_q[`BUYRUK_ADRES_BIT-1:`BLOK_OFSET_BIT], {`BLOK_OFSET_BIT{1'b0}}};
               end
            end
            BELLEK_BEKLE: begin
               // Forward the word straight from the incoming block; drop the request on the same edge.
               if (denetleyici_okuma_istek_hazir_i) begin
                  getir_buyruk_o                    <= kelime_sec(denetleyici_okuma_veri_blok_i, kelime);
                  getir_buyruk_gecerli_o            <= 1'b1;
                  denetleyici_okuma_istek_gecerli_o <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed bench for instruction_cache_controller with a 3-wait-state block-read responder.
module tb_instruction_cache_controller;

   logic         clk;
   logic         rst;
   logic [31:0]  adres;
   logic         gecerli;
   logic         hazir;
   logic [31:0]  buyruk;
   logic         buyruk_gecerli;
   logic         temizle;
   logic [31:0]  req_adres;
   logic         req;
   logic [127:0] blok;
   logic         mem_hazir;

   int vectors;
   int miscompares;
   int bekleme;

   instruction_cache_controller #(.SATIR_SAYISI(8)) dut (
      .clk_i                             (clk),
      .rst_i                             (rst),
      .getir_istek_adres_i               (adres),
      .getir_istek_gecerli_i             (gecerli),
      .getir_hazir_o                     (hazir),
      .getir_buyruk_o                    (buyruk),
      .getir_buyruk_gecerli_o            (buyruk_gecerli),
      .onbellek_temizle_i                (temizle),
      .denetleyici_okuma_istek_adres_o   (req_adres),
      .denetleyici_okuma_istek_gecerli_o (req),
      .denetleyici_okuma_veri_blok_i     (blok),
      .denetleyici_okuma_istek_hazir_i   (mem_hazir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] blok_of(input logic [31:0] a);
      logic [31:0] b;
      b = {a[31:4], 4'b0000};
      if (b == 32'h0)
         return {32'h15ef0e93, 32'h40360f33, 32'h008381b3, 32'h00940633};
      return {32'hC0DE0000 | (b + 32'd12), 32'hC0DE0000 | (b + 32'd8),
              32'hC0DE0000 | (b + 32'd4),  32'hC0DE0000 | b};
   endfunction

   // Responder: three wait-state edges with the request seen, then a one-cycle ready with data.
   always @(posedge clk) begin
      if (!rst) begin
         bekleme   <= 0;
         mem_hazir <= 1'b0;
         blok      <= '0;
      end else if (mem_hazir) begin
         mem_hazir <= 1'b0;
         bekleme   <= 0;
      end else if (req) begin
         if (bekleme == 2) begin
            mem_hazir <= 1'b1;
            blok      <= blok_of(req_adres);
         end else begin
            bekleme <= bekleme + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // flush_at: -1 none, 0 flush sampled in lookup, n>0 flush after the n-th post-accept edge.
   task automatic fetch(input logic [31:0] a, input logic [31:0] exp_word, input bit miss,
                        input int flush_at, input string tag);
      int req_cyc;
      int lat;
      bit got;
      chk({tag, " ready"}, {31'd0, hazir}, 32'd1);
      adres   = a;
      gecerli = 1'b1;
      tick();
      gecerli = 1'b0;
      if (flush_at == 0) temizle = 1'b1;
      req_cyc = 0;
      lat     = 0;
      got     = 1'b0;
      for (int n = 1; n <= 12 && !got; n++) begin
         tick();
         temizle = 1'b0;
         if (req) begin
            req_cyc++;
            if (req_cyc == 1) chk({tag, " req_adres"}, req_adres, {a[31:4], 4'b0000});
         end
         if (buyruk_gecerli) begin
            got = 1'b1;
            lat = n;
            chk({tag, " word"}, buyruk, exp_word);
         end
         if (n == flush_at) temizle = 1'b1;
      end
      chk({tag, " edges to valid"}, lat, miss ? 32'd5 : 32'd1);
      chk({tag, " req cycles"}, req_cyc, miss ? 32'd4 : 32'd0);
      tick();
      chk({tag, " valid pulse ends"}, {31'd0, buyruk_gecerli}, 32'd0);
      chk({tag, " req low after"}, {31'd0, req}, 32'd0);
   endtask

   initial begin
      int pulses;
      int req_rises;
      logic req_prev;
      logic [31:0] son_kelime;
      vectors     = 0;
      miscompares = 0;
      rst     = 1'b0;
      adres   = 32'h0;
      gecerli = 1'b0;
      temizle = 1'b0;
      repeat (3) tick();
      chk("reset buyruk", buyruk, 32'h0);
      chk("reset buyruk_gecerli", {31'd0, buyruk_gecerli}, 32'd0);
      chk("reset req", {31'd0, req}, 32'd0);
      chk("reset req_adres", req_adres, 32'h0);
      chk("reset hazir", {31'd0, hazir}, 32'd0);
      rst = 1'b1;
      tick();

      fetch(32'h04, 32'h008381b3, 1'b1, -1, "cold miss 0x04");
      fetch(32'h08, 32'h40360f33, 1'b0, -1, "hit 0x08");
      fetch(32'h80, 32'hC0DE0080, 1'b1, -1, "conflict 0x80");
      fetch(32'h00, 32'h00940633, 1'b1, -1, "refetch 0x00");
      fetch(32'h0C, 32'h15ef0e93, 1'b0, -1, "hit 0x0C");
      fetch(32'h10, 32'hC0DE0010, 1'b1, -1, "miss 0x10");
      fetch(32'h14, 32'hC0DE0014, 1'b0, -1, "hit 0x14");

      temizle = 1'b1;
      tick();
      temizle = 1'b0;
      fetch(32'h04, 32'h008381b3, 1'b1, -1, "after flush 0x04");
      fetch(32'h08, 32'h40360f33, 1'b1, 0, "flush in lookup 0x08");
      fetch(32'h10, 32'hC0DE0010, 1'b1, -1, "refill 0x10");
      fetch(32'h80, 32'hC0DE0080, 1'b1, -1, "evict to 0x80");
      fetch(32'h04, 32'h008381b3, 1'b1, 2, "flush during fill 0x04");
      fetch(32'h0C, 32'h15ef0e93, 1'b0, -1, "fill survives flush 0x0C");
      fetch(32'h14, 32'hC0DE0014, 1'b1, -1, "flushed line 0x14");

      adres   = 32'h24;
      gecerli = 1'b1;
      tick();
      gecerli = 1'b0;
      tick();
      chk("mid-miss req raised", {31'd0, req}, 32'd1);
      tick();
      rst = 1'b0;
      tick();
      chk("mid-miss reset req", {31'd0, req}, 32'd0);
      chk("mid-miss reset req_adres", req_adres, 32'h0);
      chk("mid-miss reset buyruk_gecerli", {31'd0, buyruk_gecerli}, 32'd0);
      chk("mid-miss reset hazir", {31'd0, hazir}, 32'd0);
      rst = 1'b1;
      tick();
      fetch(32'h04, 32'h008381b3, 1'b1, -1, "post-reset 0x04");

      rst     = 1'b0;
      adres   = 32'h08;
      gecerli = 1'b1;
      tick();
      chk("held req hazir low", {31'd0, hazir}, 32'd0);
      tick();
      chk("held req no response", {31'd0, buyruk_gecerli}, 32'd0);
      rst = 1'b1;
      tick();
      gecerli    = 1'b0;
      pulses     = 0;
      req_rises  = 0;
      req_prev   = 1'b0;
      son_kelime = 32'h0;
      for (int n = 0; n < 12; n++) begin
         tick();
         if (buyruk_gecerli) begin
            pulses++;
            son_kelime = buyruk;
         end
         if (req && !req_prev) req_rises++;
         req_prev = req;
      end
      chk("held req pulses", pulses, 32'd1);
      chk("held req requests", req_rises, 32'd1);
      chk("held req word", son_kelime, 32'h40360f33);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

endmodule
